pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Instruction-fetch sequencer owning the program counter of the multi-cycle MIPS core. Issues word fetches to instruction memory over a req/ack handshake, presents the fetched instruction to decode, and on decode acceptance computes the next PC: sequential, signed-offset branch, 26-bit region jump, or register jump. It also handles external flush redirects without breaking an outstanding memory handshake, and faults on illegal targets.

## Interface
- RESET_PC, 32'h0000_3000, PC loaded on reset
- IMEM_LO, 32'h0000_3000, lowest legal fetch address
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; word aligned
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  32  fetched word, valid when imem_ack=1
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr  out  32  fetched instruction
- instr_pc  out  32  address of instr
- pc4  out  32  instr_pc+4 (link value)
- instr_ready  in  1  decode accepts instr this cycle
- br_type  in  2  with instr_ready: 00 sequential, 01 branch, 10 jump, 11 jr
- br_taken  in  1  branch condition (used only when br_type=01)
- imm16  in  16  branch offset
- imm26  in  26  jump index
- ra  in  32  jr target
- flush  in  1  external redirect request
- flush_pc  in  32  redirect target
- fault  out  1  sticky illegal-target flag
- retired  out  32  count of accepted instructions

## Operation
- States: IDLE, FETCH, HOLD, DISCARD, FAULT.
- IDLE: entered on reset; next cycle -> FETCH (or FETCH at flush_pc if flush).
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_pc<=pc, -> HOLD.
- HOLD: instr_valid=1. On instr_ready: retired+=1, compute npc from instr_pc:
  - 00 or (01 and !br_taken): instr_pc+4
  - 01 and br_taken: instr_pc+4 + {{14{imm16[15]}},imm16,2'b00}
  - 10: {instr_pc[31:28], imm26, 2'b00}
  - 11: ra
  - npc legal (npc[1:0]==0 and IMEM_LO<=npc<=IMEM_HI): pc<=npc, -> FETCH; else -> FAULT.
- All adds modulo 2^32; retired wraps 0xFFFF_FFFF -> 0.
- Flush (priority over instr_ready and ack handling):
  - IDLE / HOLD: instruction dropped (not counted), pc<=flush_pc, -> FETCH.
  - FETCH with imem_ack same cycle: returned word discarded, pc<=flush_pc, -> FETCH.
  - FETCH without imem_ack: pend_pc<=flush_pc, -> DISCARD.
  - DISCARD: imem_req=1, imem_addr=old pc held until imem_ack; data discarded; then pc<=pend_pc, -> FETCH. Flush in DISCARD overwrites pend_pc (latest wins); flush coinciding with the ack uses the new flush_pc.
  - FAULT: ignored.
  - flush_pc illegal -> FAULT (after any outstanding ack in DISCARD).
- FAULT: fault=1, imem_req=0, instr_valid=0; only reset exits.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=RESET_PC, pc4=RESET_PC+4, fault=0, retired=0, state IDLE.
- Reset assertion mid-handshake abandons it immediately; memory must tolerate req dropping.
- imem_req/imem_addr stable from first request cycle through ack cycle inclusive.
- imem_ack may arrive in the first request cycle (zero wait): fetch takes 1 cycle, HOLD >=1 cycle; peak throughput 1 instruction per 2 cycles.
- instr/instr_pc/pc4 stable while instr_valid=1; instr_valid deasserts the cycle after acceptance.
- fault rises the cycle after the accepting/flushing edge; retired updates on the accepting edge.
- imem_ack outside FETCH/DISCARD is ignored.

## Test plan
- Reset release, ack on first req cycle, br_type=00 always -> imem_addr 0x3000, 0x3004, 0x3008 on successive FETCH; retired=3 after three accepts.
- HOLD at instr_pc=0x3010, br_type=01, br_taken=1, imm16=0xFFFC -> next imem_addr 0x3004; same with br_taken=0 -> 0x3014.
- instr_pc=0x3020, br_type=10, imm26=0x0000C10 -> 0x3040; br_type=11, ra=0x3400 -> 0x3400; ra=0x3402 -> fault=1, imem_req=0 permanently until reset.
- FETCH at 0x3008, ack delayed 3 cycles, flush with flush_pc=0x4000 on cycle 1 -> addr stays 0x3008 until ack, data never shown, next fetch 0x4000, retired unchanged.
- Flush and instr_ready together in HOLD with flush_pc=0x3100 -> instruction not counted, next fetch 0x3100.
- retired preloaded by 0xFFFF_FFFF accepts (or forced) plus one accept -> 0; reset asserted in DISCARD -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake,
// holds the fetched word for decode and computes the next PC on acceptance.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc4,
    input  logic        instr_ready,
    input  logic [1:0]  br_type,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] ra,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {StIdle, StFetch, StHold, StDiscard, StFault} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic [31:0] npc;
    logic [31:0] idle_pc;
    logic [31:0] disc_pc;

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= IMEM_LO) && (a <= IMEM_HI);
    endfunction

    assign pc4     = instr_pc + 32'd4;
    assign idle_pc = flush ? flush_pc : pc;
    // A flush landing on the ack cycle of a discard supersedes the pending target.
    assign disc_pc = flush ? flush_pc : pend_pc;

    // Next PC for the instruction currently held for decode.
    always_comb begin
        npc = pc4;
        case (br_type)
            2'b01:   npc = br_taken ? pc4 + {{14{imm16[15]}}, imm16, 2'b00} : pc4;
            2'b10:   npc = {instr_pc[31:28], imm26, 2'b00};
            2'b11:   npc = ra;
            default: npc = pc4;
        endcase
    end

    // Fetch state machine with registered handshake and decode outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            pc          <= RESET_PC;
            pend_pc     <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            instr_pc    <= RESET_PC;
            fault       <= 1'b0;
            retired     <= 32'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (legal(idle_pc)) begin
                        pc        <= idle_pc;
                        imem_addr <= idle_pc;
                        imem_req  <= 1'b1;
                        state     <= StFetch;
                    end else begin
                        fault    <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= StFault;
                    end
                end
                StFetch: begin
                    if (flush) begin
                        if (!imem_ack) begin
                            // Handshake still open: keep req/addr until the ack drains.
                            pend_pc <= flush_pc;
                            state   <= StDiscard;
                        end else if (legal(flush_pc)) begin
                            pc        <= flush_pc;
                            imem_addr <= flush_pc;
                        end else begin
                            fault    <= 1'b1;
                            imem_req <= 1'b0;
                            state    <= StFault;
                        end
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= StHold;
                    end
                end
                StHold: begin
                    if (flush || instr_ready) begin
                        instr_valid <= 1'b0;
                        if (!flush) begin
                            retired <= retired + 32'd1;
                        end
                        if (legal(flush ? flush_pc : npc)) begin
                            pc        <= flush ? flush_pc : npc;
                            imem_addr <= flush ? flush_pc : npc;
                            imem_req  <= 1'b1;
                            state     <= StFetch;
                        end else begin
                            fault <= 1'b1;
                            state <= StFault;
                        end
                    end
                end
                StDiscard: begin
                    if (imem_ack) begin
                        if (legal(disc_pc)) begin
                            pc        <= disc_pc;
                            imem_addr <= disc_pc;
                            state     <= StFetch;
                        end else begin
                            fault    <= 1'b1;
                            imem_req <= 1'b0;
                            state    <= StFault;
                        end
                    end else if (flush) begin
                        pend_pc <= flush_pc;
                    end
                end
                StFault: begin
                    fault       <= 1'b1;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus a randomized run, checked
// against a PC/retire-count reference model kept at the instruction level.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] LO       = 32'h0000_3000;
    localparam logic [31:0] HI       = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc4;
    logic        instr_ready;
    logic [1:0]  br_type;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] ra;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fault;
    logic [31:0] retired;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [31:0] m_pc;
    logic [31:0] m_retired;

    pc_fetch_ctrl dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .pc4(pc4), .instr_ready(instr_ready),
        .br_type(br_type), .br_taken(br_taken), .imm16(imm16), .imm26(imm26), .ra(ra),
        .flush(flush), .flush_pc(flush_pc), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic logic is_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= LO) && (a <= HI);
    endfunction

    function automatic logic [31:0] rand_legal();
        return LO + 32'd4 * $urandom_range(0, 32'hFFF);
    endfunction

    // Architectural next-PC rule, computed with plain arithmetic.
    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [1:0] br,
                                            input logic taken, input logic [15:0] i16,
                                            input logic [25:0] i26, input logic [31:0] rav);
        int off;
        off = int'($signed(i16)) * 4;
        if (br == 2'd1 && taken) return pc + 32'd4 + 32'(off);
        if (br == 2'd2) return (pc & 32'hF000_0000) + 32'(i26) * 32'd4;
        if (br == 2'd3) return rav;
        return pc + 32'd4;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_addr"}, imem_addr, RESET_PC);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_ipc"}, instr_pc, RESET_PC);
        chk({tag, "_pc4"}, pc4, RESET_PC + 4);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_retired"}, retired, 0);
    endtask

    task automatic do_reset();
        imem_ack = 0; instr_ready = 0; flush = 0;
        @(negedge clk); reset = 0;
        @(negedge clk); reset = 1;
        @(negedge clk);
        m_pc = RESET_PC; m_retired = 0;
        chk("rst_retired", retired, 0);
        chk("rst_fault", fault, 0);
    endtask

    // Serve one fetch at the model PC after lat wait cycles, then sit in HOLD.
    task automatic fetch_phase(input int lat, input int hold);
        for (int i = 0; i <= lat; i++) begin
            chk("req_fetch", imem_req, 1);
            chk("addr_fetch", imem_addr, m_pc);
            chk("valid_fetch", instr_valid, 0);
            imem_ack = (i == lat);
            imem_rdata = (i == lat) ? mem_word(m_pc) : $urandom;
            @(negedge clk);
        end
        imem_ack = 0;
        for (int h = 0; h <= hold; h++) begin
            chk("valid_hold", instr_valid, 1);
            chk("instr_hold", instr, mem_word(m_pc));
            chk("ipc_hold", instr_pc, m_pc);
            chk("pc4_hold", pc4, m_pc + 4);
            chk("req_hold", imem_req, 0);
            if (h < hold) begin
                imem_ack = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
                @(negedge clk);
            end
        end
        imem_ack = 0;
    endtask

    task automatic accept_phase(input logic [1:0] br, input logic taken, input logic [15:0] i16,
                                input logic [25:0] i26, input logic [31:0] rav);
        logic [31:0] npc;
        npc = ref_npc(m_pc, br, taken, i16, i26, rav);
        instr_ready = 1; br_type = br; br_taken = taken; imm16 = i16; imm26 = i26; ra = rav;
        @(negedge clk);
        instr_ready = 0;
        m_retired = m_retired + 1;
        chk("retired_acc", retired, m_retired);
        chk("valid_after", instr_valid, 0);
        if (is_legal(npc)) begin
            chk("fault_clear", fault, 0);
            m_pc = npc;
        end else begin
            for (int k = 0; k < 3; k++) begin
                chk("fault_set", fault, 1);
                chk("req_fault", imem_req, 0);
                chk("valid_fault", instr_valid, 0);
                flush = 1; flush_pc = LO; imem_ack = 1;
                @(negedge clk);
            end
            flush = 0; imem_ack = 0;
            chk("retired_fault", retired, m_retired);
            do_reset();
        end
    endtask

    initial begin
        logic [1:0]  rbr;
        logic [15:0] ri16;
        logic [25:0] ri26;
        logic [31:0] rra;
        logic [31:0] tgt;

        reset = 0; imem_ack = 0; imem_rdata = 0; instr_ready = 0; br_type = 0;
        br_taken = 0; imm16 = 0; imm26 = 0; ra = 0; flush = 0; flush_pc = 0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1;
        @(negedge clk);
        m_pc = RESET_PC; m_retired = 0;

        // Sequential fetches with zero-wait memory.
        for (int i = 0; i < 3; i++) begin
            fetch_phase(0, 0);
            accept_phase(2'd0, 0, 0, 0, 0);
        end
        chk("retired_three", retired, 3);

        // Branches from 0x3010, jumps, register jump and an illegal jr target.
        fetch_phase(0, 1);  accept_phase(2'd0, 0, 0, 0, 0);
        fetch_phase(0, 0);  accept_phase(2'd1, 1, 16'hFFFC, 0, 0);
        fetch_phase(1, 0);  accept_phase(2'd3, 0, 0, 0, 32'h3010);
        fetch_phase(0, 0);  accept_phase(2'd1, 0, 16'hFFFC, 0, 0);
        fetch_phase(2, 0);  accept_phase(2'd3, 0, 0, 0, 32'h3020);
        fetch_phase(0, 0);  accept_phase(2'd2, 0, 0, 26'h0000C10, 0);
        fetch_phase(0, 0);  accept_phase(2'd3, 0, 0, 0, 32'h3400);
        fetch_phase(0, 0);  accept_phase(2'd3, 0, 0, 0, 32'h3402);

        // Flush during a stalled fetch at 0x3008: old address held until the ack.
        fetch_phase(0, 0);  accept_phase(2'd0, 0, 0, 0, 0);
        fetch_phase(0, 0);  accept_phase(2'd0, 0, 0, 0, 0);
        chk("disc_addr0", imem_addr, 32'h3008);
        flush = 1; flush_pc = 32'h4000;
        @(negedge clk);
        flush = 0;
        for (int i = 0; i < 2; i++) begin
            chk("disc_req", imem_req, 1);
            chk("disc_addr", imem_addr, 32'h3008);
            chk("disc_valid", instr_valid, 0);
            @(negedge clk);
        end
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 0;
        m_pc = 32'h4000;
        chk("disc_valid_end", instr_valid, 0);
        chk("disc_retired", retired, m_retired);
        fetch_phase(1, 0);  accept_phase(2'd0, 0, 0, 0, 0);

        // Flush together with acceptance in HOLD: instruction is not counted.
        fetch_phase(0, 0);
        instr_ready = 1; flush = 1; flush_pc = 32'h3100;
        @(negedge clk);
        instr_ready = 0; flush = 0;
        chk("hflush_valid", instr_valid, 0);
        chk("hflush_retired", retired, m_retired);
        m_pc = 32'h3100;
        fetch_phase(0, 0);  accept_phase(2'd0, 0, 0, 0, 0);

        // Flush on the ack cycle of a fetch drops the returned word.
        flush = 1; flush_pc = 32'h3200; imem_ack = 1; imem_rdata = 32'h1111_2222;
        @(negedge clk);
        flush = 0; imem_ack = 0;
        chk("aflush_valid", instr_valid, 0);
        m_pc = 32'h3200;
        fetch_phase(0, 0);  accept_phase(2'd0, 0, 0, 0, 0);

        // Repeated flushes while discarding: the latest target wins.
        tgt = m_pc;
        flush = 1; flush_pc = 32'h5000;
        @(negedge clk);
        flush_pc = 32'h5100;
        @(negedge clk);
        chk("multi_addr", imem_addr, tgt);
        flush_pc = 32'h5200; imem_ack = 1;
        @(negedge clk);
        flush = 0; imem_ack = 0;
        m_pc = 32'h5200;
        fetch_phase(0, 0);

        // Retire counter wraps to zero.
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        m_retired = 32'hFFFF_FFFF;
        chk("wrap_pre", retired, m_retired);
        accept_phase(2'd0, 0, 0, 0, 0);
        chk("wrap_zero", retired, 0);

        // Illegal flush target faults only after the open handshake drains.
        flush = 1; flush_pc = 32'h7000;
        @(negedge clk);
        flush = 0;
        chk("iflush_nofault", fault, 0);
        chk("iflush_req", imem_req, 1);
        imem_ack = 1;
        @(negedge clk);
        imem_ack = 0;
        chk("iflush_fault", fault, 1);
        chk("iflush_req_off", imem_req, 0);
        do_reset();

        // Reset asserted mid-discard clears everything without a clock edge.
        fetch_phase(0, 0);  accept_phase(2'd0, 0, 0, 0, 0);
        flush = 1; flush_pc = 32'h3000;
        @(negedge clk);
        flush = 0;
        #2 reset = 0;
        #1 chk_reset_vals("async");
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        m_pc = RESET_PC; m_retired = 0;

        // Randomized instruction stream.
        for (int it = 0; it < 150; it++) begin
            fetch_phase(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 7) == 0) begin
                tgt = rand_legal();
                instr_ready = 1'($urandom_range(0, 1)); flush = 1; flush_pc = tgt;
                @(negedge clk);
                instr_ready = 0; flush = 0;
                chk("rflush_valid", instr_valid, 0);
                chk("rflush_retired", retired, m_retired);
                m_pc = tgt;
            end else begin
                rbr = 2'($urandom_range(0, 3));
                ri16 = 16'($urandom_range(0, 127)) - 16'd64;
                ri26 = ($urandom_range(0, 15) == 0) ? 26'($urandom) : 26'(rand_legal() >> 2);
                rra = ($urandom_range(0, 15) == 0) ? $urandom : rand_legal();
                accept_phase(rbr, 1'($urandom_range(0, 1)), ri16, ri26, rra);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
